regfile_param: RTL and testbench

REGFILE_PARAM -- requirements
Module: regfile_param

---
 rtl/regfile_param.sv | 119 +++++++++++
 tb/tb_regfile_param.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// Parameterised dual-read, single-write register file with a power-up clear sequence.
// Register 0 can be hardwired to zero. Reads are registered and bypass a same-cycle accepted write.
module regfile_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    output logic              ready,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    output logic              wr_drop,
    input  logic              re1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic              rvalid1,
    output logic              rvalid2
);

    localparam int NREGS = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(NREGS - 1);

    // state   | meaning
    // ST_INIT | clearing Regs[idx] one per cycle, traffic dropped
    // ST_RUN  | normal operation, left only by reset
    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t              r_state;
    logic [ADDR_W:0]     r_idx;
    logic                r_ready;
    logic                r_wr_drop;
    logic [DATA_W-1:0]   r_rdata1;
    logic [DATA_W-1:0]   r_rdata2;
    logic                r_rvalid1;
    logic                r_rvalid2;
    logic [DATA_W-1:0]   r_regs [NREGS];

    logic                w_run;
    logic                w_wr_zero;
    logic                w_wr_ok;
    logic [DATA_W-1:0]   w_rd1;
    logic [DATA_W-1:0]   w_rd2;

    assign w_run     = (r_state == ST_RUN);
    assign w_wr_zero = (ZERO_REG != 0) && (waddr == '0);
    assign w_wr_ok   = w_run && we && !w_wr_zero;

    // Register 0 is forced to zero explicitly so a read never depends on the array contents.
    always_comb begin
        w_rd1 = r_regs[raddr1];
        if ((ZERO_REG != 0) && (raddr1 == '0))
            w_rd1 = '0;
        else if (w_wr_ok && (waddr == raddr1))
            w_rd1 = wdata;
    end

    always_comb begin
        w_rd2 = r_regs[raddr2];
        if ((ZERO_REG != 0) && (raddr2 == '0))
            w_rd2 = '0;
        else if (w_wr_ok && (waddr == raddr2))
            w_rd2 = wdata;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_INIT;
            r_idx     <= '0;
            r_ready   <= 1'b0;
            r_wr_drop <= 1'b0;
            r_rdata1  <= '0;
            r_rdata2  <= '0;
            r_rvalid1 <= 1'b0;
            r_rvalid2 <= 1'b0;
        end else begin
            r_wr_drop <= we && !w_wr_ok;
            r_rvalid1 <= w_run && re1;
            r_rvalid2 <= w_run && re2;
            if (w_run && re1) r_rdata1 <= w_rd1;
            if (w_run && re2) r_rdata2 <= w_rd2;
            case (r_state)
                ST_INIT: begin
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == LAST_IDX) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    // Contents survive reset; only the INIT sweep clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (r_state == ST_INIT)
                r_regs[r_idx[ADDR_W-1:0]] <= '0;
            else if (w_wr_ok)
                r_regs[waddr] <= wdata;
        end
    end

    assign ready   = r_ready;
    assign wr_drop = r_wr_drop;
    assign rdata1  = r_rdata1;
    assign rdata2  = r_rdata2;
    assign rvalid1 = r_rvalid1;
    assign rvalid2 = r_rvalid2;

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: default 32x32 instance plus 8x16 instances with and without ZERO_REG.
module tb_regfile_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance A: defaults
    logic        a_reset, a_ready, a_we, a_wr_drop, a_re1, a_re2, a_rvalid1, a_rvalid2;
    logic [4:0]  a_waddr, a_raddr1, a_raddr2;
    logic [31:0] a_wdata, a_rdata1, a_rdata2;

    // Instances B (ZERO_REG=1) and C (ZERO_REG=0) share inputs
    logic        b_reset, b_we, b_re1, b_re2;
    logic [2:0]  b_waddr, b_raddr1, b_raddr2;
    logic [15:0] b_wdata;
    logic        b_ready, b_wr_drop, b_rvalid1, b_rvalid2;
    logic [15:0] b_rdata1, b_rdata2;
    logic        c_ready, c_wr_drop, c_rvalid1, c_rvalid2;
    logic [15:0] c_rdata1, c_rdata2;

    regfile_param u_a (
        .clk(clk), .reset(a_reset), .ready(a_ready),
        .we(a_we), .waddr(a_waddr), .wdata(a_wdata), .wr_drop(a_wr_drop),
        .re1(a_re1), .re2(a_re2), .raddr1(a_raddr1), .raddr2(a_raddr2),
        .rdata1(a_rdata1), .rdata2(a_rdata2), .rvalid1(a_rvalid1), .rvalid2(a_rvalid2)
    );

    regfile_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1)) u_b (
        .clk(clk), .reset(b_reset), .ready(b_ready),
        .we(b_we), .waddr(b_waddr), .wdata(b_wdata), .wr_drop(b_wr_drop),
        .re1(b_re1), .re2(b_re2), .raddr1(b_raddr1), .raddr2(b_raddr2),
        .rdata1(b_rdata1), .rdata2(b_rdata2), .rvalid1(b_rvalid1), .rvalid2(b_rvalid2)
    );

    regfile_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0)) u_c (
        .clk(clk), .reset(b_reset), .ready(c_ready),
        .we(b_we), .waddr(b_waddr), .wdata(b_wdata), .wr_drop(c_wr_drop),
        .re1(b_re1), .re2(b_re2), .raddr1(b_raddr1), .raddr2(b_raddr2),
        .rdata1(c_rdata1), .rdata2(c_rdata2), .rvalid1(c_rvalid1), .rvalid2(c_rvalid2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        a_reset = 1'b0; a_we = 1'b1; a_waddr = 5'd4; a_wdata = 32'h1111_1111;
        a_re1 = 1'b1; a_re2 = 1'b1; a_raddr1 = 5'd4; a_raddr2 = 5'd4;
        b_reset = 1'b0; b_we = 1'b0; b_waddr = 3'd0; b_wdata = 16'h0;
        b_re1 = 1'b0; b_re2 = 1'b0; b_raddr1 = 3'd0; b_raddr2 = 3'd0;

        // Reset: outputs quiet even with traffic present
        repeat (3) tick();
        chk("rst_ready",   {31'b0, a_ready},   32'd0);
        chk("rst_wr_drop", {31'b0, a_wr_drop}, 32'd0);
        chk("rst_rvalid1", {31'b0, a_rvalid1}, 32'd0);
        chk("rst_rvalid2", {31'b0, a_rvalid2}, 32'd0);
        chk("rst_rdata1",  a_rdata1,           32'd0);
        chk("rst_rdata2",  a_rdata2,           32'd0);

        // Release; ready after exactly 32 edges, reads in INIT ignored
        a_we = 1'b0; a_re2 = 1'b0; a_raddr1 = 5'd0;
        a_reset = 1'b1;
        for (int c = 1; c <= 32; c++) begin
            tick();
            if (c == 31) begin
                chk("init_ready_c31", {31'b0, a_ready},   32'd0);
                chk("init_rvalid1",   {31'b0, a_rvalid1}, 32'd0);
            end
        end
        chk("init_ready_c32", {31'b0, a_ready}, 32'd1);
        a_re1 = 1'b0;

        // Cleared contents
        a_re1 = 1'b1; a_raddr1 = 5'd31; a_re2 = 1'b1; a_raddr2 = 5'd17;
        tick();
        chk("clr_rdata1",  a_rdata1,           32'd0);
        chk("clr_rvalid1", {31'b0, a_rvalid1}, 32'd1);
        chk("clr_rdata2",  a_rdata2,           32'd0);
        chk("clr_rvalid2", {31'b0, a_rvalid2}, 32'd1);
        a_re1 = 1'b0; a_re2 = 1'b0;
        tick();
        chk("rvalid1_pulse", {31'b0, a_rvalid1}, 32'd0);

        // Write then read r5
        a_we = 1'b1; a_waddr = 5'd5; a_wdata = 32'hDEAD_BEEF;
        tick();
        chk("w5_wr_drop", {31'b0, a_wr_drop}, 32'd0);
        a_we = 1'b0; a_re1 = 1'b1; a_raddr1 = 5'd5;
        tick();
        chk("r5_rdata1",  a_rdata1,           32'hDEAD_BEEF);
        chk("r5_rvalid1", {31'b0, a_rvalid1}, 32'd1);
        a_re1 = 1'b0;

        // Bypass on both ports to the same address
        a_we = 1'b1; a_waddr = 5'd9; a_wdata = 32'h1234_5678;
        a_re1 = 1'b1; a_raddr1 = 5'd9; a_re2 = 1'b1; a_raddr2 = 5'd9;
        tick();
        chk("byp_rdata2", a_rdata2, 32'h1234_5678);
        chk("byp_rdata1", a_rdata1, 32'h1234_5678);
        a_we = 1'b0; a_re1 = 1'b0; a_re2 = 1'b0;

        // Write to r0 is dropped, no bypass
        a_we = 1'b1; a_waddr = 5'd0; a_wdata = 32'hFFFF_FFFF;
        a_re1 = 1'b1; a_raddr1 = 5'd0;
        tick();
        chk("z_wr_drop", {31'b0, a_wr_drop}, 32'd1);
        chk("z_rdata1",  a_rdata1,           32'd0);
        chk("z_rvalid1", {31'b0, a_rvalid1}, 32'd1);
        a_we = 1'b0; a_re1 = 1'b0;
        a_re2 = 1'b1; a_raddr2 = 5'd0;
        tick();
        chk("z_wr_drop_end", {31'b0, a_wr_drop}, 32'd0);
        chk("z_rdata2",      a_rdata2,           32'd0);
        a_re2 = 1'b0;

        // Hold behaviour: rdata1 keeps 7 while r3 is rewritten
        a_we = 1'b1; a_waddr = 5'd3; a_wdata = 32'd7;
        tick();
        a_we = 1'b0; a_re1 = 1'b1; a_raddr1 = 5'd3;
        tick();
        chk("r3_rdata1", a_rdata1, 32'd7);
        a_re1 = 1'b0; a_we = 1'b1; a_wdata = 32'd9;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("hold_rdata1",  a_rdata1,           32'd7);
            chk("hold_rvalid1", {31'b0, a_rvalid1}, 32'd0);
        end
        a_we = 1'b0; a_re1 = 1'b1;
        tick();
        chk("r3_new", a_rdata1, 32'd9);
        a_re1 = 1'b0;

        // Top address, no wrap onto lower registers
        a_we = 1'b1; a_waddr = 5'd31; a_wdata = 32'hA5A5_5A5A;
        tick();
        a_we = 1'b0; a_re1 = 1'b1; a_raddr1 = 5'd31; a_re2 = 1'b1; a_raddr2 = 5'd15;
        tick();
        chk("r31_rdata1", a_rdata1, 32'hA5A5_5A5A);
        chk("r15_rdata2", a_rdata2, 32'd0);
        a_re1 = 1'b0; a_re2 = 1'b0;

        // Reset in RUN, then again at idx=10 of INIT
        a_reset = 1'b0;
        tick();
        chk("rrst_ready",  {31'b0, a_ready}, 32'd0);
        chk("rrst_rdata1", a_rdata1,         32'd0);
        a_reset = 1'b1;
        repeat (10) tick();
        chk("mid_init_ready", {31'b0, a_ready}, 32'd0);
        a_reset = 1'b0;
        tick();
        a_reset = 1'b1; a_we = 1'b1; a_waddr = 5'd12; a_wdata = 32'hCAFE_0000;
        tick();
        chk("init_wr_drop", {31'b0, a_wr_drop}, 32'd1);
        a_we = 1'b0;
        for (int c = 2; c <= 32; c++) begin
            tick();
            if (c == 2)  chk("init_wr_drop_end", {31'b0, a_wr_drop}, 32'd0);
            if (c == 31) chk("re_ready_c31",     {31'b0, a_ready},   32'd0);
        end
        chk("re_ready_c32", {31'b0, a_ready}, 32'd1);
        a_re1 = 1'b1; a_raddr1 = 5'd12; a_re2 = 1'b1; a_raddr2 = 5'd5;
        tick();
        chk("r12_after_init", a_rdata1, 32'd0);
        chk("r5_recleared",   a_rdata2, 32'd0);
        a_re1 = 1'b0; a_re2 = 1'b0;

        // Small instances: 8 registers of 16 bits
        b_reset = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 7) begin
                chk("b_ready_c7", {31'b0, b_ready}, 32'd0);
                chk("c_ready_c7", {31'b0, c_ready}, 32'd0);
            end
        end
        chk("b_ready_c8", {31'b0, b_ready}, 32'd1);
        chk("c_ready_c8", {31'b0, c_ready}, 32'd1);
        b_we = 1'b1; b_waddr = 3'd7; b_wdata = 16'hBEEF;
        tick();
        b_waddr = 3'd0; b_wdata = 16'h1234;
        tick();
        chk("b_r0_wr_drop", {31'b0, b_wr_drop}, 32'd1);
        chk("c_r0_wr_drop", {31'b0, c_wr_drop}, 32'd0);
        b_we = 1'b0; b_re1 = 1'b1; b_raddr1 = 3'd7; b_re2 = 1'b1; b_raddr2 = 3'd0;
        tick();
        chk("b_r7_rdata1", {16'b0, b_rdata1}, 32'h0000_BEEF);
        chk("c_r7_rdata1", {16'b0, c_rdata1}, 32'h0000_BEEF);
        chk("b_r0_rdata2", {16'b0, b_rdata2}, 32'h0000_0000);
        chk("c_r0_rdata2", {16'b0, c_rdata2}, 32'h0000_1234);
        b_re1 = 1'b0; b_re2 = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
